// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: captures decode-stage fields for EX, with bubble, hold and WB refresh.
// Optional build macro ID_EX_BUBBLE_CNT_EN adds a 32-bit bubble_cnt output counting inserted bubbles.
module id_ex_reg #(
    parameter int DW = 32,
    parameter int TW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stall_clr,
    input  logic          hold,
    input  logic          valid_1,
    input  logic [DW-1:0] PC_1,
    input  logic [DW-1:0] regRD1_1,
    input  logic [DW-1:0] regRD2_1,
    input  logic [DW-1:0] imm_1,
    input  logic [5:0]    op_1,
    input  logic [5:0]    func_1,
    input  logic [4:0]    rs_1,
    input  logic [4:0]    rt_1,
    input  logic [4:0]    A3_1,
    input  logic [TW-1:0] Tnew_1,
    input  logic          regWE_4,
    input  logic [4:0]    A3_4,
    input  logic [DW-1:0] WD_4,
`ifdef ID_EX_BUBBLE_CNT_EN
    output logic [31:0]   bubble_cnt,
`endif
    output logic          valid_2,
    output logic [DW-1:0] PC_2,
    output logic [DW-1:0] regRD1_2,
    output logic [DW-1:0] regRD2_2,
    output logic [DW-1:0] imm_2,
    output logic [5:0]    op_2,
    output logic [5:0]    func_2,
    output logic [4:0]    rs_2,
    output logic [4:0]    rt_2,
    output logic [4:0]    A3_2,
    output logic [TW-1:0] Tnew_2
);

    // Slot protocol: valid_1/valid_2 mark a real instruction in the ID/EX slot. There is
    // no ready; hold is the only backpressure and freezes the slot regardless of stall_clr.
    logic          wb_hit;
    logic [TW-1:0] tnew_next;

    assign wb_hit    = valid_2 && regWE_4 && (A3_4 != 5'd0);
    assign tnew_next = (!valid_1 || Tnew_1 == '0) ? '0 : Tnew_1 - TW'(1);

    always_ff @(posedge clk) begin
        if (reset || (stall_clr && !hold)) begin
            // Reset and bubble share the all-zero NOP pattern; A3_2 = 0 never forwards.
            valid_2  <= 1'b0;
            PC_2     <= '0;
            regRD1_2 <= '0;
            regRD2_2 <= '0;
            imm_2    <= '0;
            op_2     <= '0;
            func_2   <= '0;
            rs_2     <= '0;
            rt_2     <= '0;
            A3_2     <= '0;
            Tnew_2   <= '0;
        end else if (hold) begin
            if (wb_hit && A3_4 == rs_2) regRD1_2 <= WD_4;
            if (wb_hit && A3_4 == rt_2) regRD2_2 <= WD_4;
        end else begin
            valid_2  <= valid_1;
            PC_2     <= PC_1;
            regRD1_2 <= regRD1_1;
            regRD2_2 <= regRD2_1;
            imm_2    <= imm_1;
            op_2     <= op_1;
            func_2   <= func_1;
            rs_2     <= rs_1;
            rt_2     <= rt_1;
            A3_2     <= A3_1;
            Tnew_2   <= tnew_next;
        end
    end

`ifdef ID_EX_BUBBLE_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_cnt <= '0;
        end else if (stall_clr && !hold) begin
            bubble_cnt <= bubble_cnt + 32'd1;
        end
    end
`endif

endmodule
